// File: rtl/pb_arb_pkg.sv
// Shared types and helpers for the packet playback arbiter.
package pb_arb_pkg;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    // Ceiling log2, minimum result 1 so index ports never collapse to zero width.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Binary index of a one-hot vector (up to 32 channels); zero input gives 0.
    function automatic int unsigned onehot_to_idx(input logic [31:0] oh);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (oh[i]) begin
                idx = idx | i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_prio_n.sv
// Combinational round-robin picker: first set bit of ready at or after the
// one-hot prio position, wrapping cyclically. Output is one-hot or zero.
module rr_prio_n #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] ready,
    input  logic [N-1:0] prio,
    output logic [N-1:0] select
);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] pick;

    // Doubled vector lets the subtract-and-mask trick handle the wrap-around:
    // a hit above prio lands in the low copy, a wrapped hit in the high copy.
    always_comb begin
        dbl    = {ready, ready};
        pick   = dbl & ~(dbl - {{N{1'b0}}, prio});
        select = pick[N-1:0] | pick[2*N-1:N];
    end

endmodule

// File: rtl/packet_pb_arbiter.sv
// Round-robin packet playback arbiter for N traffic-generator channels.
// Holds a grant for a whole multi-flit packet and rotates priority only when
// the packet completes. Optional per-channel grant counters are compiled in
// when PB_ARB_GRANT_CNT_EN is defined.
module packet_pb_arbiter
    import pb_arb_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned LEN_W = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [N-1:0]           ready,
    input  logic [N-1:0]           request,
    input  logic [N*LEN_W-1:0]     burst_len,
    input  logic                   flit_ack,
`ifdef PB_ARB_GRANT_CNT_EN
    input  logic [clog2(N)-1:0]    stat_sel,
    output logic [CNT_W-1:0]       stat_cnt,
`endif
    output logic [N-1:0]           select,
    output logic [clog2(N)-1:0]    sel_idx,
    output logic                   sel_valid,
    output logic                   done
);

    localparam int unsigned IW = clog2(N);

    state_t             state_q;
    logic [N-1:0]       select_q;
    logic [N-1:0]       prio_q;
    logic [IW-1:0]      sel_idx_q;
    logic               sel_valid_q;
    logic [LEN_W-1:0]   remain_q;

    logic [N-1:0]       cand;
    logic [N-1:0]       win;
    logic               grant;
    int unsigned        win_idx;
    logic [IW-1:0]      idx_d;
    logic [LEN_W-1:0]   len_d;

    // Channels eligible for a new grant.
    always_comb begin
        cand = enable ? (ready & request) : '0;
    end

    rr_prio_n #(.N(N)) u_rr_prio (
        .ready  (cand),
        .prio   (prio_q),
        .select (win)
    );

    // Grant-time values: winner index and its packet length (0 counts as 1).
    always_comb begin
        win_idx = onehot_to_idx(32'(win));
        idx_d   = IW'(win_idx);
        len_d   = burst_len[win_idx*LEN_W +: LEN_W];
        if (len_d == '0) begin
            len_d = LEN_W'(1);
        end
        grant   = (state_q == IDLE) && (|cand);
    end

    // Last flit of the packet; suppressed by reset so an aborted packet never pulses.
    assign done = (state_q == BUSY) && flit_ack && (remain_q == LEN_W'(1)) && !reset;

    // Packet FSM: grant in IDLE, count acks in BUSY, rotate priority on completion.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            select_q    <= '0;
            sel_idx_q   <= '0;
            sel_valid_q <= 1'b0;
            remain_q    <= '0;
            prio_q      <= N'(1);
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        state_q     <= BUSY;
                        select_q    <= win;
                        sel_idx_q   <= idx_d;
                        sel_valid_q <= 1'b1;
                        remain_q    <= len_d;
                    end
                end
                BUSY: begin
                    if (flit_ack) begin
                        remain_q <= remain_q - LEN_W'(1);
                        if (remain_q == LEN_W'(1)) begin
                            state_q     <= IDLE;
                            select_q    <= '0;
                            sel_valid_q <= 1'b0;
                            prio_q      <= {select_q[N-2:0], select_q[N-1]};
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign select    = select_q;
    assign sel_idx   = sel_idx_q;
    assign sel_valid = sel_valid_q;

`ifdef PB_ARB_GRANT_CNT_EN
    logic [N-1:0][CNT_W-1:0] cnt_q;

    // Saturating per-channel grant counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (grant) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (win[i] && (cnt_q[i] != '1)) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Combinational statistics read; out-of-range selects read as zero.
    always_comb begin
        stat_cnt = '0;
        if (32'(stat_sel) < N) begin
            stat_cnt = cnt_q[stat_sel];
        end
    end
`endif

endmodule

// File: tb/tb_packet_pb_arbiter.sv
// Self-checking bench for packet_pb_arbiter with N=4.
module tb_packet_pb_arbiter;

    localparam int unsigned N     = 4;
    localparam int unsigned LEN_W = 4;
    localparam int unsigned CNT_W = 2;

    logic         clock = 1'b0;
    logic         reset;
    logic         enable;
    logic [3:0]   ready;
    logic [3:0]   request;
    logic [15:0]  burst_len;
    logic         flit_ack;
    logic [3:0]   select;
    logic [1:0]   sel_idx;
    logic         sel_valid;
    logic         done;
`ifdef PB_ARB_GRANT_CNT_EN
    logic [1:0]   stat_sel = 2'd0;
    logic [1:0]   stat_cnt;
`endif

    int total = 0;
    int bad   = 0;

    packet_pb_arbiter #(
        .N     (N),
        .LEN_W (LEN_W),
        .CNT_W (CNT_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .ready     (ready),
        .request   (request),
        .burst_len (burst_len),
        .flit_ack  (flit_ack),
`ifdef PB_ARB_GRANT_CNT_EN
        .stat_sel  (stat_sel),
        .stat_cnt  (stat_cnt),
`endif
        .select    (select),
        .sel_idx   (sel_idx),
        .sel_valid (sel_valid),
        .done      (done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        en;
        logic [3:0]  rdy;
        logic [3:0]  req;
        logic [15:0] blen;
        logic [3:0]  exp_sel;
        logic [1:0]  exp_idx;
        int unsigned acks;
    } vec_t;

    vec_t        vecs[6];
    int unsigned exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clk();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        flit_ack = 1'b0;
        enable   = 1'b0;
        ready    = '0;
        request  = '0;
        clk();
        reset    = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int last;
        int grants;
        logic prev_valid;
        int unsigned e;

        // en, ready, request, burst_len, expected select, expected idx, acks
        vecs[0] = '{1'b1, 4'b0100, 4'b0100, 16'h0300, 4'b0100, 2'd2, 3};
        vecs[1] = '{1'b1, 4'b1111, 4'b1010, 16'h0020, 4'b0010, 2'd1, 2};
        vecs[2] = '{1'b1, 4'b1001, 4'b1111, 16'h0001, 4'b0001, 2'd0, 1};
        vecs[3] = '{1'b1, 4'b1000, 4'b1000, 16'h0000, 4'b1000, 2'd3, 1};
        vecs[4] = '{1'b0, 4'b1111, 4'b1111, 16'h1111, 4'b0000, 2'd0, 0};
        vecs[5] = '{1'b1, 4'b1100, 4'b0110, 16'h0F00, 4'b0100, 2'd2, 15};

        reset = 1'b1; enable = 1'b0; ready = '0; request = '0;
        burst_len = '0; flit_ack = 1'b0;
        clk();
        clk();
        reset = 1'b0;
        chk("reset_select", 32'(select), 32'(0));
        chk("reset_sel_idx", 32'(sel_idx), 32'(0));
        chk("reset_sel_valid", 32'(sel_valid), 32'(0));
        chk("reset_done", 32'(done), 32'(0));

        // Table: single packet from a fresh reset (priority at ch0).
        for (int v = 0; v < 6; v++) begin
            do_reset();
            enable    = vecs[v].en;
            ready     = vecs[v].rdy;
            request   = vecs[v].req;
            burst_len = vecs[v].blen;
            clk();
            chk($sformatf("vec%0d_valid", v), 32'(sel_valid), 32'(vecs[v].exp_sel != 4'b0));
            chk($sformatf("vec%0d_select", v), 32'(select), 32'(vecs[v].exp_sel));
            if (vecs[v].exp_sel != 4'b0)
                chk($sformatf("vec%0d_idx", v), 32'(sel_idx), 32'(vecs[v].exp_idx));
            for (int unsigned k = 1; k <= vecs[v].acks; k++) begin
                flit_ack = 1'b1;
                #1;
                chk($sformatf("vec%0d_done_ack%0d", v, k), 32'(done), 32'(k == vecs[v].acks));
                clk();
            end
            flit_ack = 1'b0;
            chk($sformatf("vec%0d_end_valid", v), 32'(sel_valid), 32'(0));
            chk($sformatf("vec%0d_end_select", v), 32'(select), 32'(0));
        end

        // ch2 packet of 3, then all request: priority must have moved to ch3.
        do_reset();
        enable = 1'b1; ready = 4'b0100; request = 4'b0100; burst_len = 16'h0300;
        clk();
        chk("t1_select", 32'(select), 32'(4'b0100));
        ready = 4'b1111; request = 4'b1111; burst_len = 16'h1111;
        for (int k = 1; k <= 3; k++) begin
            flit_ack = 1'b1;
            #1;
            chk("t1_done", 32'(done), 32'(k == 3));
            clk();
        end
        flit_ack = 1'b0;
        chk("t1_gap_valid", 32'(sel_valid), 32'(0));
        clk();
        chk("t1_regrant_valid", 32'(sel_valid), 32'(1));
        chk("t1_regrant_select", 32'(select), 32'(4'b1000));

        // Scoreboard: all channels, len=1, continuous acks.
        do_reset();
        enable = 1'b1; ready = 4'b1111; request = 4'b1111; burst_len = 16'h1111;
        flit_ack = 1'b1;
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
        exp_q.push_back(3); exp_q.push_back(0);
        last = -1;
        prev_valid = 1'b0;
        for (int cyc = 0; cyc < 30 && exp_q.size() > 0; cyc++) begin
            clk();
            if (sel_valid && !prev_valid) begin
                e = exp_q.pop_front();
                chk("rr_order", 32'(sel_idx), 32'(e));
                chk("rr_onehot", 32'(select), 32'(1) << e);
                chk("rr_done", 32'(done), 32'(1));
                if (last >= 0) chk("rr_period", 32'(cyc - last), 32'(2));
                last = cyc;
            end
            prev_valid = sel_valid;
        end
        chk("rr_pending", 32'(exp_q.size()), 32'(0));
        flit_ack = 1'b0;

        // ch1 len=4; enable/request/burst_len changes mid-packet are ignored.
        do_reset();
        enable = 1'b1; ready = 4'b0010; request = 4'b0010; burst_len = 16'h0040;
        clk();
        chk("t3_select", 32'(select), 32'(4'b0010));
        flit_ack = 1'b1;
        #1;
        chk("t3_done_ack1", 32'(done), 32'(0));
        clk();
        enable = 1'b0; ready = 4'b1111; request = 4'b1101; burst_len = 16'h0010;
        for (int k = 2; k <= 4; k++) begin
            #1;
            chk("t3_done", 32'(done), 32'(k == 4));
            chk("t3_held", 32'(select), 32'(4'b0010));
            clk();
        end
        flit_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("t3_no_grant", 32'(sel_valid), 32'(0));
            clk();
        end

        // Reset during BUSY (remain=2) clears the grant and priority.
        do_reset();
        enable = 1'b1; ready = 4'b1111; request = 4'b0001; burst_len = 16'h0301;
        clk();
        chk("t4_first", 32'(select), 32'(4'b0001));
        flit_ack = 1'b1;
        #1;
        chk("t4_first_done", 32'(done), 32'(1));
        clk();
        request = 4'b0100; flit_ack = 1'b0;
        clk();
        chk("t4_ch2", 32'(select), 32'(4'b0100));
        flit_ack = 1'b1;
        clk();
        reset = 1'b1;
        #1;
        chk("t4_no_done_in_reset", 32'(done), 32'(0));
        clk();
        reset = 1'b0; flit_ack = 1'b0;
        chk("t4_rst_select", 32'(select), 32'(0));
        chk("t4_rst_valid", 32'(sel_valid), 32'(0));
        request = 4'b1111;
        clk();
        chk("t4_prio_ch0", 32'(select), 32'(4'b0001));

        // burst_len=0 on ch3 acts as 1; ack gaps stretch BUSY.
        do_reset();
        enable = 1'b1; ready = 4'b1000; request = 4'b1000; burst_len = 16'h0000;
        clk();
        chk("t5_select", 32'(select), 32'(4'b1000));
        request = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            chk("t5_gap_valid", 32'(sel_valid), 32'(1));
            chk("t5_gap_done", 32'(done), 32'(0));
            clk();
        end
        flit_ack = 1'b1;
        #1;
        chk("t5_done", 32'(done), 32'(1));
        clk();
        chk("t5_end_valid", 32'(sel_valid), 32'(0));
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("t5_idle_ack_done", 32'(done), 32'(0));
            clk();
        end
        flit_ack = 1'b0;

`ifdef PB_ARB_GRANT_CNT_EN
        // Grant counter for ch1 saturates at 3 with CNT_W=2.
        do_reset();
        stat_sel = 2'd1;
        #1;
        chk("t6_cnt_reset", 32'(stat_cnt), 32'(0));
        enable = 1'b1; ready = 4'b0010; request = 4'b0010; burst_len = 16'h0010;
        flit_ack = 1'b1;
        grants = 0;
        prev_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            clk();
            if (sel_valid && !prev_valid) grants++;
            prev_valid = sel_valid;
            if (k == 3) chk("t6_cnt_two", 32'(stat_cnt), 32'(2));
        end
        chk("t6_grants", 32'(grants), 32'(5));
        chk("t6_cnt_sat", 32'(stat_cnt), 32'(3));
        stat_sel = 2'd0;
        #1;
        chk("t6_cnt_ch0", 32'(stat_cnt), 32'(0));
        flit_ack = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
